mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control unit for the RV32I core: a Moore FSM that sequences one shared ALU, the unified instruction/data memory port and the register file over 3–5 cycles per instruction.
- Drives every datapath mux select and write enable, plus the 2-bit ALUOp consumed by the existing ALU decoder.
- Adds a memory-ready stall handshake, an illegal-opcode trap and a retire pulse for the performance counter.

Parameters:
- MEM_WAIT_EN, 1, when 1 the fetch and memory states wait for mem_ready; when 0 mem_ready is treated as constant 1.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous active-low reset.
- op  in  7  opcode from the instruction register; stable from DECODE to instruction end.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register and OldPC enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- ALUSrcB  out  2  B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode from funct.
- ImmSrc  out  2  immediate format: I=00, S=01, B=10, J=11.
- RegWrite  out  1  register file write enable.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  level; high while in ILLEGAL.

Behaviour:
- State and encoding:
  - States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL.
  - Async reset forces FETCH.
  - While reset is low, PCWrite, IRWrite, MemWrite, RegWrite and retire are forced 0; all other outputs take their FETCH values.
  - Reset mid-instruction abandons that instruction with no further writes.
- Outputs are decoded from the state register (Moore), except:
  - PCWrite = PCUpdate | (Branch & zero).
  - ImmSrc is combinational from op.
  - Stall gating of IRWrite/PCUpdate/MemWrite as listed per state.
- Unlisted outputs are 0 in every state.
- Per-state outputs:
  - FETCH: AdrSrc=0; ALUSrcA=00; ALUSrcB=10; ALUOp=00; ResultSrc=10; IRWrite=PCUpdate=mem_ready.
  - DECODE: ALUSrcA=01; ALUSrcB=01; ALUOp=00 (branch target precompute).
  - MEMADR: ALUSrcA=10; ALUSrcB=01; ALUOp=00.
  - MEMREAD: AdrSrc=1; ResultSrc=00.
  - MEMWB: ResultSrc=01; RegWrite=1; retire=1.
  - MEMWRITE: AdrSrc=1; ResultSrc=00; MemWrite=1 held until mem_ready; retire=mem_ready.
  - EXECUTER: ALUSrcA=10; ALUSrcB=00; ALUOp=10.
  - EXECUTEI: ALUSrcA=10; ALUSrcB=01; ALUOp=10.
  - ALUWB: ResultSrc=00; RegWrite=1; retire=1.
  - BEQ: ALUSrcA=10; ALUSrcB=00; ALUOp=01; ResultSrc=00; Branch=1; retire=1.
  - JAL: ALUSrcA=01; ALUSrcB=10; ALUOp=00; ResultSrc=00; PCUpdate=1.
  - ILLEGAL: illegal=1; all enables 0.
- Transitions:
  - FETCH→DECODE when mem_ready, else stay.
  - DECODE by op:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - any other → ILLEGAL.
  - MEMADR→MEMREAD when op=0000011, else MEMWRITE.
  - MEMREAD→MEMWB when mem_ready.
  - MEMWB→FETCH.
  - MEMWRITE→FETCH when mem_ready.
  - EXECUTER/EXECUTEI→ALUWB.
  - ALUWB→FETCH.
  - BEQ→FETCH.
  - JAL→ALUWB.
  - ILLEGAL holds until reset.
- ImmSrc: 0100011→01, 1100011→10, 1101111→11, all others→00.
- Latency with mem_ready=1:
  - lw 5 cycles.
  - sw 4 cycles.
  - R-type and I-type 4 cycles.
  - beq 3 cycles.
  - jal 4 cycles.
- Each cycle of mem_ready=0 in a waiting state adds one cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL);
  - encodings for ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc.
- One sub-module, mc_mainfsm, holds the state register, next-state logic and the per-state output decode.
- The top level adds the ImmSrc decoder and PCWrite logic.

Test Plan:
- Reset low mid-MEMWRITE, then high → state FETCH; MemWrite=0 during reset; FETCH outputs (ALUSrcB=10, ResultSrc=10) visible; first IRWrite only after release with mem_ready=1.
- lw, op=0000011, mem_ready=1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and retire=1 only in cycle 5; ResultSrc=01.
- sw, op=0100011, mem_ready low for 2 cycles in MEMWRITE → MemWrite high 3 cycles; retire only in the cycle mem_ready=1; ImmSrc=01.
- beq, op=1100011:
  - zero=1 → PCWrite=1 in cycle 3; ALUOp=01.
  - zero=0 → PCWrite=0 throughout BEQ; retire=1 in both cases.
- jal, op=1101111 → JAL cycle has PCWrite=1, ALUSrcA=01, ALUSrcB=10; next cycle ALUWB with RegWrite=1; ImmSrc=11.
- op=0110111 (unsupported) → DECODE→ILLEGAL; illegal=1 and all enables 0 for 10+ cycles; reset returns to FETCH with illegal=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// Every datapath select value used by the FSM and the top level is defined here.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Raw per-state controls; enables are gated by reset at the top level.
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       retire;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_mainfsm.sv
// Main Moore FSM of the multicycle controller: state register, next-state
// logic and per-state control decode.
module mc_mainfsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ok,
  output ctrl_t      ctrl
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // The store strobe stays up for the whole MEMWRITE stay; only retire waits for ready.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = mem_ok;
        ctrl.pc_update  = mem_ok;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
        ctrl.retire     = mem_ok;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit top: wraps the main FSM, adds the ImmSrc decoder,
// branch-qualified PCWrite and the reset gating of all write enables.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       retire,
  output logic       illegal
);

  ctrl_t ctrl;
  logic  mem_ok;

  assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

  mc_mainfsm u_mainfsm (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .mem_ok (mem_ok),
    .ctrl   (ctrl)
  );

  // While reset is held the FSM already sits in FETCH, so only the enables need masking.
  assign PCWrite   = reset & (ctrl.pc_update | (ctrl.branch & zero));
  assign IRWrite   = reset & ctrl.ir_write;
  assign MemWrite  = reset & ctrl.mem_write;
  assign RegWrite  = reset & ctrl.reg_write;
  assign retire    = reset & ctrl.retire;

  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign illegal   = ctrl.illegal;
  assign ImmSrc    = imm_sel(op);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: each instruction is expanded into its
// list of datapath phases and every cycle is compared against that plan.
module tb_mc_controller;

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_ADDR   = 2;
  localparam int P_READ   = 3;
  localparam int P_LOADWB = 4;
  localparam int P_STORE  = 5;
  localparam int P_EXEC_R = 6;
  localparam int P_EXEC_I = 7;
  localparam int P_REGWB  = 8;
  localparam int P_BRANCH = 9;
  localparam int P_LINK   = 10;
  localparam int P_TRAP   = 11;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] immsrc;
    logic       regwrite;
    logic       retire;
    logic       illegal;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

  int n_total = 0;
  int n_pass  = 0;

  mc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .RegWrite  (RegWrite),
    .retire    (retire),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t a;
    a.pcwrite   = PCWrite;
    a.adrsrc    = AdrSrc;
    a.memwrite  = MemWrite;
    a.irwrite   = IRWrite;
    a.resultsrc = ResultSrc;
    a.srca      = ALUSrcA;
    a.srcb      = ALUSrcB;
    a.aluop     = ALUOp;
    a.immsrc    = ImmSrc;
    a.regwrite  = RegWrite;
    a.retire    = retire;
    a.illegal   = illegal;
    return a;
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // What the datapath must be told during one phase of an instruction.
  function automatic obs_t expected(input int ph, input logic [6:0] o,
                                    input logic rdy, input logic z);
    obs_t e;
    e = '0;
    e.immsrc = imm_ref(o);
    case (ph)
      P_FETCH:  begin e.pcwrite = rdy; e.irwrite = rdy; e.resultsrc = 2'b10; e.srcb = 2'b10; end
      P_DECODE: begin e.srca = 2'b01; e.srcb = 2'b01; end
      P_ADDR:   begin e.srca = 2'b10; e.srcb = 2'b01; end
      P_READ:   begin e.adrsrc = 1'b1; end
      P_LOADWB: begin e.resultsrc = 2'b01; e.regwrite = 1'b1; e.retire = 1'b1; end
      P_STORE:  begin e.adrsrc = 1'b1; e.memwrite = 1'b1; e.retire = rdy; end
      P_EXEC_R: begin e.srca = 2'b10; e.srcb = 2'b00; e.aluop = 2'b10; end
      P_EXEC_I: begin e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 2'b10; end
      P_REGWB:  begin e.regwrite = 1'b1; e.retire = 1'b1; end
      P_BRANCH: begin e.srca = 2'b10; e.aluop = 2'b01; e.pcwrite = z; e.retire = 1'b1; end
      P_LINK:   begin e.srca = 2'b01; e.srcb = 2'b10; e.pcwrite = 1'b1; end
      P_TRAP:   begin e.illegal = 1'b1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  function automatic bit waits_on_mem(input int ph);
    return (ph == P_FETCH) || (ph == P_READ) || (ph == P_STORE);
  endfunction

  // wait_lo < 0: random readiness; otherwise each memory phase stalls wait_lo cycles.
  // zero_mode < 0: random zero flag; otherwise zero is forced to zero_mode.
  // abort_at >= 0: stop after that many cycles, leaving the instruction mid-flight.
  task automatic run_instr(input logic [6:0] o, input int wait_lo, input int zero_mode,
                           input int abort_at, input string name);
    int   plan[$];
    int   idx;
    int   cycles;
    int   stalls;
    logic rdy;
    logic z;
    obs_t e;
    obs_t a;
    plan = {P_FETCH, P_DECODE};
    case (o)
      7'b0000011: plan = {plan, P_ADDR, P_READ, P_LOADWB};
      7'b0100011: plan = {plan, P_ADDR, P_STORE};
      7'b0110011: plan = {plan, P_EXEC_R, P_REGWB};
      7'b0010011: plan = {plan, P_EXEC_I, P_REGWB};
      7'b1100011: plan = {plan, P_BRANCH};
      7'b1101111: plan = {plan, P_LINK, P_REGWB};
      default:    for (int k = 0; k < 12; k++) plan.push_back(P_TRAP);
    endcase
    idx = 0;
    cycles = 0;
    stalls = 0;
    while (idx < plan.size() && cycles < 400 && cycles != abort_at) begin
      @(negedge clk);
      if (idx == 0) op = o;
      if (wait_lo >= 0 && waits_on_mem(plan[idx])) rdy = (stalls >= wait_lo);
      else rdy = ($urandom_range(99) < 65);
      z = (zero_mode < 0) ? 1'($urandom_range(1)) : 1'(zero_mode);
      mem_ready = rdy;
      zero = z;
      #1;
      e = expected(plan[idx], o, rdy, z);
      a = observe();
      n_total++;
      if (a !== e) $display("[TB] FAIL %s cycle %0d phase %0d: got %h, want %h", name, cycles, plan[idx], a, e);
      else n_pass++;
      cycles++;
      if (waits_on_mem(plan[idx]) && !rdy) stalls++;
      else begin idx++; stalls = 0; end
    end
    if (abort_at < 0) begin
      n_total++;
      if (idx != plan.size()) $display("[TB] FAIL %s timeout: reached phase %0d, want %0d", name, idx, plan.size());
      else n_pass++;
    end
  endtask

  task automatic check_now(input obs_t e, input string name);
    obs_t a;
    a = observe();
    n_total++;
    if (a !== e) $display("[TB] FAIL %s: got %h, want %h", name, a, e);
    else n_pass++;
  endtask

  // Hold reset with mem_ready high (enables must stay low), then release stalled.
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b1; op = 7'b0000011;
    #1 check_now(expected(P_FETCH, op, 1'b0, zero), "reset_hold");
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1 check_now(expected(P_FETCH, op, 1'b0, zero), "reset_release");
  endtask

  task automatic test_load();
    run_instr(7'b0000011, 0, -1, -1, "lw");
    run_instr(7'b0000011, 2, -1, -1, "lw_stall");
  endtask

  task automatic test_store();
    run_instr(7'b0100011, 2, -1, -1, "sw_stall");
    run_instr(7'b0100011, 0, -1, -1, "sw");
  endtask

  task automatic test_branch();
    run_instr(7'b1100011, 0, 1, -1, "beq_taken");
    run_instr(7'b1100011, 0, 0, -1, "beq_not_taken");
  endtask

  task automatic test_jal();
    run_instr(7'b1101111, 0, -1, -1, "jal");
  endtask

  task automatic test_alu();
    run_instr(7'b0110011, 1, -1, -1, "rtype");
    run_instr(7'b0010011, 0, -1, -1, "itype");
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    for (int i = 0; i < 40; i++) run_instr(ops[$urandom_range(5)], -1, -1, -1, "random");
  endtask

  // Reset lands two cycles into a stalled store; no write may leak out.
  task automatic test_reset_mid_store();
    run_instr(7'b0100011, 3, -1, 8, "sw_abort");
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1;
    #1 check_now(expected(P_FETCH, op, 1'b0, zero), "abort_in_reset");
    @(negedge clk);
    reset = 1'b1;
    #1 check_now(expected(P_FETCH, op, 1'b1, zero), "abort_release_fetch");
    #1 mem_ready = 1'b0;
  endtask

  task automatic test_illegal();
    run_instr(7'b0110111, 0, -1, -1, "illegal");
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1;
    #1 check_now(expected(P_FETCH, op, 1'b0, zero), "illegal_reset");
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1 check_now(expected(P_FETCH, op, 1'b0, zero), "illegal_release");
  endtask

  initial begin
    reset = 1'b0;
    op = 7'b0;
    zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_jal();
    test_alu();
    test_back_to_back();
    test_reset_mid_store();
    test_illegal();
    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
